ft_rollback_ctrl: RTL
=====================

Name: ft_rollback_ctrl

Overview:
- Sits directly downstream of the lockstep register-write comparator and consumes its compared write stream (write enable, address, data, mismatch signal).
- Matching writes are committed into a shadow register file that holds the last known-good architectural state.
- On a mismatch it halts both cores, streams the shadow contents back into both core register files, then releases the cores.
- Repeated consecutive failures escalate to a sticky fatal flag.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 32, number of architectural registers; x0 is never stored or restored.
- MAX_RETRY, 3, number of consecutive rollbacks with no good commit in between that triggers fatal.
- CNT_WIDTH, 8, width of the total-rollback counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- we_i  in  1  compared write valid from the comparator.
- addr_i  in  ADDR_WIDTH  compared write address (comparator addr_o).
- data_i  in  DATA_WIDTH  compared write data (comparator data_o).
- error_i  in  1  comparator mismatch signal; 1 means the cores disagree.
- halt_ack_i  in  1  both cores report halted (AND of per-core acks, done outside this block).
- halt_o  out  1  halt request to both cores.
- restore_we_o  out  1  register-file restore write enable to both cores.
- restore_addr_o  out  ADDR_WIDTH  restore address.
- restore_data_o  out  DATA_WIDTH  restore data.
- resume_o  out  1  single-cycle release pulse.
- fatal_o  out  1  sticky unrecoverable-error flag.
- rollback_cnt_o  out  CNT_WIDTH  total rollbacks since reset; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high):
  - state=RUN; every shadow entry cleared to 0; retry counter=0.
  - All outputs are 0.
- States: RUN, HALT, RESTORE, RESUME, FAIL. The state is registered and all outputs are registered.
- RUN:
  - Commit: we_i=1, error_i=0, addr_i!=0 writes shadow[addr_i]<=data_i on the edge; the retry counter clears.
  - Writes to addr 0 are dropped but still clear the retry counter.
  - error_i=1 in any cycle, regardless of we_i: the write is NOT committed.
  - On that error, if retry+1 >= MAX_RETRY, go to FAIL; otherwise retry++, rollback_cnt_o++ (saturating), and go to HALT.
  - halt_o rises the cycle after error_i is sampled.
- HALT:
  - halt_o=1; wait for halt_ack_i=1, then go to RESTORE with index=1.
  - we_i and error_i are ignored.
- RESTORE:
  - One register per cycle: restore_we_o=1, restore_addr_o=index, restore_data_o=shadow[index].
  - The index increments; after index NUM_REGS-1 is driven, go to RESUME.
  - This is exactly NUM_REGS-1 cycles (31 by default). halt_o stays 1.
  - we_i and error_i are ignored.
- RESUME:
  - One cycle with resume_o=1, halt_o=0, restore_we_o=0, then return to RUN.
  - The retry counter is not cleared here; only a good commit clears it.
- FAIL:
  - halt_o=1 and fatal_o=1, held until reset.
  - No restore; all inputs are ignored.
- Latency:
  - Error to halt_o: 1 cycle.
  - halt_ack_i to first restore write: 1 cycle.
  - Last restore write to resume_o: 1 cycle.
- Simultaneous events:
  - Shadow reads during RESTORE are never concurrent with commits, so a single read port and single write port suffice.
  - A commit in the same cycle as a transition out of RUN cannot happen, because error_i blocks the commit.
- An error on the first cycle after RESUME is a new rollback, with the retry counter still incremented from before.
- halt_ack_i deasserting during RESTORE is ignored; the sequence completes.
- Reset mid-RESTORE or mid-HALT: asynchronous return to reset state, with the shadow cleared.

Decomposition:
- Package ft_pkg holds:
  - rollback_state_e, the enum RUN/HALT/RESTORE/RESUME/FAIL;
  - defaults for ADDR_WIDTH and DATA_WIDTH;
  - the REG_ZERO constant.
- Sub-module ft_shadow_regfile:
  - NUM_REGS x DATA_WIDTH;
  - one synchronous write port and one combinational read port;
  - asynchronous reset clears it;
  - writes to address 0 are suppressed internally.
- The top level holds the FSM, the restore index, the retry counter and the rollback counter.

Test Plan:
- Commit path: we=1, error=0, addr=10, data=100, then addr=11, data=200.
  - Forced rollback restores shadow[10]=100 and shadow[11]=200; all other registers restore as 0.
- Mismatch: after committing addr=10, data=100, drive we=1, addr=10, data=120, error=1.
  - halt_o=1 on the next cycle.
  - After halt_ack_i, 31 restore writes with addr 1..31; addr 10 carries 100, not 120.
  - Then a one-cycle resume_o, and rollback_cnt_o=1.
- addr 0: we=1, addr=0, data=55, error=0, then force a rollback.
  - No restore write targets addr 0, and no restored value is 55.
- Escalation: three consecutive errors with no good commit between them.
  - First two produce full rollbacks and rollback_cnt_o=2; the third raises fatal_o and halt_o with no restore.
  - fatal_o persists until rst_i.
- Retry clear: error, rollback, one good commit, error, rollback, good commit, error.
  - fatal_o stays 0 and rollback_cnt_o=3.
- Reset mid-RESTORE: assert rst_i at restore index 15.
  - All outputs go to 0 immediately (asynchronously), and a subsequent rollback restores all zeros.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types and constants for the lockstep rollback controller.
package ft_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int REG_ZERO       = 0;

    typedef enum logic [2:0] {
        RUN,
        HALT,
        RESTORE,
        RESUME,
        FAIL
    } rollback_state_e;

endpackage

// File: rtl/ft_shadow_regfile.sv
// Known-good architectural register copy: one write port, one combinational read port.
module ft_shadow_regfile
    import ft_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    // Entry 0 never accepts a write, so it stays at its reset value of zero.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mem_q[gi] <= '0;
                end else if (we_i && (gi != REG_ZERO) && (waddr_i == ADDR_WIDTH'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ft_rollback_ctrl.sv
// Commits compared writes to a shadow file; on mismatch halts the cores, replays
// the shadow into both register files and releases them, escalating to fatal.
module ft_rollback_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = 32,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  error_i,
    input  logic                  halt_ack_i,
    output logic                  halt_o,
    output logic                  restore_we_o,
    output logic [ADDR_WIDTH-1:0] restore_addr_o,
    output logic [DATA_WIDTH-1:0] restore_data_o,
    output logic                  resume_o,
    output logic                  fatal_o,
    output logic [CNT_WIDTH-1:0]  rollback_cnt_o
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    rollback_state_e       state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] idx_d;
    logic [RETRY_W-1:0]    retry_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  halt_q;
    logic                  rwe_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  resume_q;
    logic                  fatal_q;

    logic                  commit;
    logic                  retry_full;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign commit     = (state_q == RUN) && we_i && !error_i;
    assign retry_full = (int'(retry_q) + 1) >= MAX_RETRY;
    assign idx_d      = idx_q + 1'b1;
    assign cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    // Look one entry ahead so the registered restore data lines up with idx_q.
    assign rd_addr    = (state_q == RESTORE) ? idx_d : ADDR_WIDTH'(1);

    ft_shadow_regfile #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shadow (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (commit),
        .waddr_i(addr_i),
        .wdata_i(data_i),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            idx_q    <= '0;
            retry_q  <= '0;
            cnt_q    <= '0;
            halt_q   <= 1'b0;
            rwe_q    <= 1'b0;
            rdata_q  <= '0;
            resume_q <= 1'b0;
            fatal_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (error_i) begin
                        halt_q <= 1'b1;
                        if (retry_full) begin
                            fatal_q <= 1'b1;
                            state_q <= FAIL;
                        end else begin
                            retry_q <= retry_q + 1'b1;
                            cnt_q   <= cnt_d;
                            state_q <= HALT;
                        end
                    end else if (we_i) begin
                        retry_q <= '0;
                    end
                end
                HALT: begin
                    if (halt_ack_i) begin
                        rwe_q   <= 1'b1;
                        idx_q   <= ADDR_WIDTH'(1);
                        rdata_q <= rd_data;
                        state_q <= RESTORE;
                    end
                end
                RESTORE: begin
                    if (idx_q == LAST_IDX) begin
                        rwe_q    <= 1'b0;
                        idx_q    <= '0;
                        rdata_q  <= '0;
                        halt_q   <= 1'b0;
                        resume_q <= 1'b1;
                        state_q  <= RESUME;
                    end else begin
                        idx_q   <= idx_d;
                        rdata_q <= rd_data;
                    end
                end
                RESUME: begin
                    resume_q <= 1'b0;
                    state_q  <= RUN;
                end
                FAIL: begin
                    halt_q  <= 1'b1;
                    fatal_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign halt_o         = halt_q;
    assign restore_we_o   = rwe_q;
    assign restore_addr_o = idx_q;
    assign restore_data_o = rdata_q;
    assign resume_o       = resume_q;
    assign fatal_o        = fatal_q;
    assign rollback_cnt_o = cnt_q;

endmodule
